// File: rtl/uart_defs.sv
// Shared UART definitions: FSM encoding, frame shape and bit-period derivation.
// TX and RX both import this so they compute BIT_PERIOD identically.
package uart_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Integer truncation; callers must keep the result >= 2.
  function automatic int bit_period(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Restartable bit-period counter; bit_done marks the last cycle of each bit.
module uart_baud_timer #(
  parameter int BIT_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int W = $clog2(BIT_PERIOD) + 1;
  localparam logic [W-1:0] LAST = W'(BIT_PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || bit_done) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register behind valid/ready.
// tx and busy are registered from the current state, so both lag the FSM by one cycle.
module uart_tx
  import uart_defs::*;
#(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] UART_TX_Data_In,
  input  logic       UART_TX_Valid_In,
  output logic       UART_TX_Ready_Out,
  output logic       UART_TX_Busy_Out,
  output logic       tx
);

  localparam int BIT_PERIOD = bit_period(CLOCK_RATE, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        ready_q;
  logic        busy_q, busy_d;
  logic        tx_q, tx_d;
  logic        load, accept;
  logic        restart, bit_done;

  uart_baud_timer #(.BIT_PERIOD(BIT_PERIOD)) u_baud_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_done (bit_done)
  );

  assign accept = UART_TX_Valid_In & ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      busy_q      <= busy_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_BIT) state_d = ST_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // load needs a full holder and accept needs an empty one, so they never coincide
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_d      = UART_TX_Data_In;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d  = (state_q != ST_IDLE) | hold_full_q;
    restart = (state_q == ST_IDLE) | (state_d != state_q);
  end

  assign UART_TX_Ready_Out = ready_q;
  assign UART_TX_Busy_Out  = busy_q;
  assign tx                = tx_q;

endmodule
